bit_unpacker_512bits: RTL and testbench



---
 rtl/bit_unpacker_512bits.sv | 97 +++++++++
 tb/tb_bit_unpacker_512bits.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_unpacker_512bits.sv
// Bit-stream reader: buffers 256-bit stream words in a 512-bit MSB-aligned
// register and exposes the next 32 unread bits for a variable-length consumer.
module bit_unpacker_512bits (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic [255:0] data_in,
   input  logic         data_in_valid,
   output logic         data_in_ready,
   input  logic         consume,
   input  logic [5:0]   consume_len,
   output logic [31:0]  window,
   output logic         window_valid,
   output logic [9:0]   avail_bits,
   output logic         underflow_err
);

   localparam int IN_W  = 256;
   localparam int WIN_W = 32;
   localparam int BUF_W = 2 * IN_W;

   logic [BUF_W-1:0] buf_r;
   logic [9:0]       count_r;
   logic             err_r;

   logic             legal_s;
   logic             accept_s;
   logic [BUF_W-1:0] buf_cons_s;
   logic [9:0]       count_cons_s;
   logic [BUF_W-1:0] ins_s;
   logic [BUF_W-1:0] buf_next_s;
   logic [9:0]       count_next_s;
   logic             err_next_s;

   // All outputs are decoded from registered state only.
   assign window        = buf_r[BUF_W-1 -: WIN_W];
   assign avail_bits    = count_r;
   assign window_valid  = (count_r >= 10'd32);
   assign data_in_ready = (count_r <= 10'd256);
   assign underflow_err = err_r;

   // Consume step followed by accept step; ready uses the pre-consume count,
   // which bounds the post-insert count at 512.
   always_comb begin
      legal_s      = 1'b0;
      accept_s     = 1'b0;
      buf_cons_s   = buf_r;
      count_cons_s = count_r;
      ins_s        = {BUF_W{1'b0}};
      buf_next_s   = buf_r;
      count_next_s = count_r;
      err_next_s   = err_r;

      legal_s = consume && (consume_len <= 6'd32) && ({4'd0, consume_len} <= count_r);
      if (legal_s) begin
         buf_cons_s   = buf_r << consume_len;
         count_cons_s = count_r - {4'd0, consume_len};
      end else begin
         buf_cons_s   = buf_r;
         count_cons_s = count_r;
      end

      if (consume && !legal_s) begin
         err_next_s = 1'b1;
      end else begin
         err_next_s = err_r;
      end

      accept_s = data_in_valid && data_in_ready;
      ins_s    = {data_in, {IN_W{1'b0}}} >> count_cons_s;
      if (accept_s) begin
         buf_next_s   = buf_cons_s | ins_s;
         count_next_s = count_cons_s + 10'd256;
      end else begin
         buf_next_s   = buf_cons_s;
         count_next_s = count_cons_s;
      end
   end

   // State register: reset clears everything, flush clears only the buffered bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_r   <= {BUF_W{1'b0}};
         count_r <= 10'd0;
         err_r   <= 1'b0;
      end else if (flush) begin
         buf_r   <= {BUF_W{1'b0}};
         count_r <= 10'd0;
         err_r   <= err_r;
      end else begin
         buf_r   <= buf_next_s;
         count_r <= count_next_s;
         err_r   <= err_next_s;
      end
   end

endmodule

// File: tb/tb_bit_unpacker_512bits.sv
// Self-checking bench for bit_unpacker_512bits against a bit-queue stream model.
module tb_bit_unpacker_512bits;

   logic         clk;
   logic         reset;
   logic         flush;
   logic [255:0] data_in;
   logic         data_in_valid;
   logic         data_in_ready;
   logic         consume;
   logic [5:0]   consume_len;
   logic [31:0]  window;
   logic         window_valid;
   logic [9:0]   avail_bits;
   logic         underflow_err;

   int n_checks = 0;
   int n_fail   = 0;

   bit mq[$];
   bit m_err;

   bit_unpacker_512bits dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .consume       (consume),
      .consume_len   (consume_len),
      .window        (window),
      .window_valid  (window_valid),
      .avail_bits    (avail_bits),
      .underflow_err (underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_window();
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (i < mq.size()) w[31-i] = mq[i];
      end
      return w;
   endfunction

   function automatic logic [255:0] rand_word();
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // One clock: apply inputs, advance the stream model, sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [255:0] d, input logic c,
                       input logic [5:0] len, input logic f);
      bit ready;
      data_in_valid = v;
      data_in       = d;
      consume       = c;
      consume_len   = len;
      flush         = f;
      if (f) begin
         mq.delete();
      end else begin
         ready = (mq.size() <= 256);
         if (c) begin
            if (len <= 32 && len <= mq.size()) begin
               repeat (len) void'(mq.pop_front());
            end else begin
               m_err = 1'b1;
            end
         end
         if (v && ready) begin
            for (int i = 255; i >= 0; i--) mq.push_back(d[i]);
         end
      end
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      consume       = 1'b0;
      consume_len   = 6'd0;
      flush         = 1'b0;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      data_in_valid = 1'b1;
      data_in       = rand_word();
      repeat (2) @(posedge clk);
      #1;
      reset         = 1'b0;
      data_in_valid = 1'b0;
      mq.delete();
      m_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (avail_bits !== 10'd0 || data_in_ready !== 1'b1 || window !== 32'd0 ||
          window_valid !== 1'b0 || underflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: avail=%0d ready=%b win=%h wv=%b err=%b, want 0 1 0 0 0",
                  avail_bits, data_in_ready, window, window_valid, underflow_err);
      end
      step(1'b1, {32{8'hA5}}, 1'b0, 6'd0, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd256 || window !== 32'hA5A5A5A5 || window_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_word: avail=%0d win=%h wv=%b, want 256 a5a5a5a5 1",
                  avail_bits, window, window_valid);
      end
   endtask

   task automatic test_consume_seq();
      logic [255:0] w;
      logic [5:0]   lens [3];
      int           tot;
      lens[0] = 6'd4; lens[1] = 6'd12; lens[2] = 6'd16;
      do_reset();
      w = rand_word();
      w[255:224] = 32'hDEADBEEF;
      step(1'b1, w, 1'b0, 6'd0, 1'b0);
      n_checks++;
      if (window !== 32'hDEADBEEF || avail_bits !== 10'd256) begin
         n_fail++;
         $display("FAIL consume_load: win=%h avail=%0d, want deadbeef 256", window, avail_bits);
      end
      tot = 0;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 256'd0, 1'b1, lens[k], 1'b0);
         tot += int'(lens[k]);
         n_checks++;
         if (window !== w[255-tot -: 32] || avail_bits !== 10'(256 - tot)) begin
            n_fail++;
            $display("FAIL consume_step%0d: win=%h avail=%0d, want %h %0d",
                     k, window, avail_bits, w[255-tot -: 32], 256 - tot);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      do_reset();
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      step(1'b1, rand_word(), 1'b1, 6'd32, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd480 || data_in_ready !== 1'b0 || window !== m_window()) begin
         n_fail++;
         $display("FAIL full_accept: avail=%0d ready=%b win=%h, want 480 0 %h",
                  avail_bits, data_in_ready, window, m_window());
      end
      cyc = 0;
      while (mq.size() > 256 && cyc < 20) begin
         step(1'b1, rand_word(), 1'b1, 6'd32, 1'b0);
         cyc++;
         n_checks++;
         if (data_in_ready !== (mq.size() <= 256) || avail_bits !== 10'(mq.size()) ||
             window !== m_window()) begin
            n_fail++;
            $display("FAIL drain: ready=%b avail=%0d win=%h, want %b %0d %h", data_in_ready,
                     avail_bits, window, mq.size() <= 256, mq.size(), m_window());
         end
      end
      n_checks++;
      if (avail_bits !== 10'd256 || data_in_ready !== 1'b1 || cyc != 7) begin
         n_fail++;
         $display("FAIL drain_end: avail=%0d ready=%b cycles=%0d, want 256 1 7",
                  avail_bits, data_in_ready, cyc);
      end
   endtask

   task automatic test_straddle();
      logic [255:0] w;
      do_reset();
      w = rand_word();
      step(1'b1, w, 1'b0, 6'd0, 1'b0);
      repeat (7) step(1'b0, 256'd0, 1'b1, 6'd32, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd12, 1'b0);
      step(1'b1, {16'hFFFF, 240'd0}, 1'b1, 6'd0, 1'b0);
      n_checks++;
      if (window[31:12] !== w[19:0] || window[11:0] !== 12'hFFF || avail_bits !== 10'd276) begin
         n_fail++;
         $display("FAIL straddle: win=%h avail=%0d, want %h_fff 276", window, avail_bits, w[19:0]);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      repeat (7) step(1'b0, 256'd0, 1'b1, 6'd32, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd22, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd11, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd10 || underflow_err !== 1'b1 || window !== m_window()) begin
         n_fail++;
         $display("FAIL underflow_11: avail=%0d err=%b win=%h, want 10 1 %h",
                  avail_bits, underflow_err, window, m_window());
      end
      step(1'b1, rand_word(), 1'b1, 6'd5, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd261 || underflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_sticky: avail=%0d err=%b, want 261 1", avail_bits, underflow_err);
      end
      do_reset();
      n_checks++;
      if (underflow_err !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_reset: err=%b, want 0", underflow_err);
      end
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd33, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd512 || underflow_err !== 1'b1 || window !== m_window()) begin
         n_fail++;
         $display("FAIL underflow_33: avail=%0d err=%b win=%h, want 512 1 %h",
                  avail_bits, underflow_err, window, m_window());
      end
   endtask

   task automatic test_flush();
      do_reset();
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      repeat (6) step(1'b0, 256'd0, 1'b1, 6'd32, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd20, 1'b0);
      step(1'b1, rand_word(), 1'b0, 6'd0, 1'b0);
      step(1'b0, 256'd0, 1'b1, 6'd33, 1'b0);
      n_checks++;
      if (avail_bits !== 10'd300 || underflow_err !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_setup: avail=%0d err=%b, want 300 1", avail_bits, underflow_err);
      end
      step(1'b1, rand_word(), 1'b1, 6'd8, 1'b1);
      n_checks++;
      if (avail_bits !== 10'd0 || window !== 32'd0 || underflow_err !== 1'b1 ||
          data_in_ready !== 1'b1 || window_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: avail=%0d win=%h err=%b ready=%b wv=%b, want 0 0 1 1 0",
                  avail_bits, window, underflow_err, data_in_ready, window_valid);
      end
   endtask

   task automatic test_random();
      logic       v, c, f;
      logic [5:0] len;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         c   = ($urandom_range(0, 3) != 0);
         len = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
         f   = ($urandom_range(0, 127) == 0);
         if (i == 1000) begin
            do_reset();
         end
         step(v, rand_word(), c, len, f);
         n_checks++;
         if (window !== m_window() || avail_bits !== 10'(mq.size()) ||
             window_valid !== (mq.size() >= 32) || data_in_ready !== (mq.size() <= 256) ||
             underflow_err !== m_err) begin
            n_fail++;
            $display("FAIL random[%0d]: win=%h avail=%0d wv=%b rdy=%b err=%b, want %h %0d %b %b %b",
                     i, window, avail_bits, window_valid, data_in_ready, underflow_err,
                     m_window(), mq.size(), mq.size() >= 32, mq.size() <= 256, m_err);
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      data_in       = 256'd0;
      data_in_valid = 1'b0;
      consume       = 1'b0;
      consume_len   = 6'd0;
      m_err         = 1'b0;
      test_reset();
      test_consume_seq();
      test_back_to_back();
      test_straddle();
      test_underflow();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
